pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register, the generic successor to the fixed ID/EX latch. It carries a control bundle and a data payload between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer, synchronous flush to a configurable bubble encoding, and a saturating bubble-cycle counter. It is instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of hand-written latches.

---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush to a
// bubble encoding, and a saturating count of cycles with no valid output.
module pipe_stage_reg #(
  parameter int                DATA_W         = 160,
  parameter int                CTRL_W         = 12,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE    = 12'h004,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              skid_valid_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic              in_fire_s;
  logic              out_fire_s;

  // in_ready depends only on stored state, so there is no path from out_ready.
  assign in_ready   = ~skid_valid_r;
  assign in_fire_s  = in_valid & ~skid_valid_r;
  assign out_fire_s = main_valid_r & out_ready;

  assign out_valid  = main_valid_r;
  assign out_ctrl   = main_valid_r ? main_ctrl_r : CTRL_BUBBLE;
  assign out_data   = main_data_r;
  assign occupancy  = {main_valid_r & skid_valid_r, main_valid_r ^ skid_valid_r};
  assign bubble_cnt = bubble_cnt_r;

  // Entry storage: head (main) and skid slots, with flush taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_ctrl_r <= {CTRL_W{1'b0}};
        main_data_r <= {DATA_W{1'b0}};
        skid_ctrl_r <= {CTRL_W{1'b0}};
        skid_data_r <= {DATA_W{1'b0}};
      end
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (in_fire_s) begin
            main_valid_r <= 1'b1;
            main_ctrl_r  <= in_ctrl;
            main_data_r  <= in_data;
          end
        end
        2'b10: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
          end else if (in_fire_s) begin
            skid_valid_r <= 1'b1;
            skid_ctrl_r  <= in_ctrl;
            skid_data_r  <= in_data;
          end else if (out_fire_s) begin
            main_valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (out_fire_s) begin
            main_ctrl_r  <= skid_ctrl_r;
            main_data_r  <= skid_data_r;
            skid_valid_r <= 1'b0;
          end
        end
        default: begin
          // Skid valid without a head cannot occur; recover to empty.
          main_valid_r <= 1'b0;
          skid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of edges with no valid head; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!main_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench for pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;
  localparam int DW = 160;
  localparam int CW = 12;
  localparam int NW = 3;
  localparam logic [CW-1:0] BUB = 12'h004;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [NW-1:0] bubble_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CLEAR_ON_FLUSH(1'b1), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy),
    .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];      // model contents, head first
  ent_t sb_q[$];    // entries the DUT still owes downstream
  logic [DW-1:0] shown;
  int cnt_m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    shown = '0;
    cnt_m = 0;
  endtask

  task automatic check_status();
    int n = mq.size();
    chk("out_valid", DW'(out_valid), DW'(n > 0));
    chk("in_ready", DW'(in_ready), DW'(n < 2));
    chk("occupancy", DW'(occupancy), DW'(n));
    chk("out_ctrl", DW'(out_ctrl), DW'((n > 0) ? mq[0].c : BUB));
    chk("out_data", out_data, shown);
    chk("bubble_cnt", DW'(bubble_cnt), DW'(cnt_m));
  endtask

  // Apply the rules of one clock edge to the queue model.
  task automatic model_edge();
    int n = mq.size();
    logic inf, outf;
    inf  = in_valid && (n < 2);
    outf = (n > 0) && out_ready;
    if (cnt_clr) cnt_m = 0;
    else if (n == 0 && cnt_m < CNT_MAX) cnt_m++;
    if (flush) begin
      mq.delete();
      sb_q.delete();
      shown = '0;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) begin
        mq.push_back('{c: in_ctrl, d: in_data});
        sb_q.push_back('{c: in_ctrl, d: in_data});
      end
    end
    if (mq.size() > 0) shown = mq[0].d;
  endtask

  // Starts and ends on a falling edge.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic clr);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    #4;
    check_status();
    @(posedge clk);
    #1;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int k, input logic ordy);
    for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  // Monitor: every handshake on the output must match the oldest owed entry.
  initial begin
    forever begin
      ent_t e;
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got ctrl %0h expected no output", out_ctrl);
        end else begin
          e = sb_q.pop_front();
          chk("sb_ctrl", DW'(out_ctrl), DW'(e.c));
          chk("sb_data", out_data, e.d);
        end
      end
    end
  end

  initial begin
    int val;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(5, 1'b0);
    chk("idle_bubble_cnt", DW'(bubble_cnt), DW'(5));
    chk("idle_out_ctrl", DW'(out_ctrl), DW'(BUB));

    // Full-rate streaming.
    for (int i = 1; i <= 8; i++) cycle(1'b1, CW'(i), rnd_data(), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Stall for two cycles mid-stream; hold each entry until accepted.
    val = 1;
    for (int k = 1; k <= 20 && val <= 6; k++) begin
      logic acc;
      acc = (mq.size() < 2);
      cycle(1'b1, CW'(val), rnd_data(), !(k == 3 || k == 4), 1'b0, 1'b0);
      if (acc) val++;
    end
    chk("stall_all_sent", DW'(val), DW'(7));
    idle(3, 1'b1);

    // Flush while full, with a new entry offered the same edge.
    cycle(1'b1, CW'(5), rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, CW'(6), rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("full_occ", DW'(occupancy), DW'(2));
    cycle(1'b1, CW'(7), rnd_data(), 1'b0, 1'b1, 1'b0);
    chk("flush_occ", DW'(occupancy), DW'(0));
    chk("flush_data", out_data, '0);
    idle(3, 1'b1);

    // Counter saturation and clear.
    idle(10, 1'b1);
    chk("cnt_sat", DW'(bubble_cnt), DW'(CNT_MAX));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("cnt_clr", DW'(bubble_cnt), DW'(0));
    idle(2, 1'b1);
    chk("cnt_after_clr", DW'(bubble_cnt), DW'(2));

    // Asynchronous reset while full, checked before any clock edge.
    cycle(1'b1, CW'(9), rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, CW'(10), rnd_data(), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occ", DW'(occupancy), DW'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", DW'(out_valid), DW'(0));
    chk("arst_occ", DW'(occupancy), DW'(0));
    chk("arst_ready", DW'(in_ready), DW'(1));
    chk("arst_ctrl", DW'(out_ctrl), DW'(BUB));
    chk("arst_data", out_data, '0);
    chk("arst_cnt", DW'(bubble_cnt), DW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Random traffic with occasional flush and counter clear.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 3) != 0, CW'($urandom()), rnd_data(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0);
    idle(4, 1'b1);
    chk("drained", DW'(sb_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
